// File: rtl/pulse_stretcher_if.sv
// Trigger/control and stretched-pulse status bundle for pulse_stretcher.
// The master drives the request and configuration side; the slave is the stretcher.
interface pulse_stretcher_if #(
  parameter int CNT_W  = 16,
  parameter int DROP_W = 8
);
  logic              i_enable;
  logic              i_trig;
  logic [CNT_W-1:0]  i_width;
  logic [CNT_W-1:0]  i_gap;
  logic              i_retrig;
  logic              i_clr_drop;
  logic              o_pulse;
  logic              o_busy;
  logic              o_done;
  logic [DROP_W-1:0] o_drop_cnt;

  modport master (
    output i_enable, i_trig, i_width, i_gap, i_retrig, i_clr_drop,
    input  o_pulse, o_busy, o_done, o_drop_cnt
  );

  modport slave (
    input  i_enable, i_trig, i_width, i_gap, i_retrig, i_clr_drop,
    output o_pulse, o_busy, o_done, o_drop_cnt
  );
endinterface

// File: rtl/pulse_stretcher.sv
// Expands single-cycle triggers into a timed high pulse followed by an optional
// forced-low guard gap, and counts triggers that arrive while it cannot take them.
module pulse_stretcher #(
  parameter int CNT_W  = 16,
  parameter int DROP_W = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  pulse_stretcher_if.slave   ps
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  gap_len;
  logic              pulse;
  logic              busy;
  logic              done;
  logic [DROP_W-1:0] drop_cnt;
  logic              trig_drop;

  // A zero width still produces a one-cycle pulse.
  function automatic logic [CNT_W-1:0] width_floor(input logic [CNT_W-1:0] w);
    return (w == '0) ? CNT_W'(1) : w;
  endfunction

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Drops only exist while enabled; a disabling cycle silently discards triggers.
  assign trig_drop = ps.i_enable && ps.i_trig &&
                     (((state == HIGH) && !ps.i_retrig) || (state == GAP));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state    <= IDLE;
      count    <= '0;
      gap_len  <= '0;
      pulse    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      drop_cnt <= '0;
    end else begin
      done <= 1'b0;

      if (ps.i_clr_drop)
        drop_cnt <= '0;
      else if (trig_drop)
        drop_cnt <= sat_inc(drop_cnt);

      if (!ps.i_enable) begin
        state   <= IDLE;
        count   <= '0;
        gap_len <= '0;
        pulse   <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (ps.i_trig) begin
              state   <= HIGH;
              count   <= width_floor(ps.i_width);
              gap_len <= ps.i_gap;
              pulse   <= 1'b1;
              busy    <= 1'b1;
            end
          end

          HIGH: begin
            // A retrigger on the final high cycle still extends without a low glitch.
            if (ps.i_trig && ps.i_retrig) begin
              count   <= width_floor(ps.i_width);
              gap_len <= ps.i_gap;
            end else if (count == CNT_W'(1)) begin
              pulse <= 1'b0;
              done  <= 1'b1;
              if (gap_len != '0) begin
                state <= GAP;
                count <= gap_len;
              end else begin
                state <= IDLE;
                count <= '0;
                busy  <= 1'b0;
              end
            end else begin
              count <= count - 1'b1;
            end
          end

          GAP: begin
            if (count == CNT_W'(1)) begin
              state <= IDLE;
              count <= '0;
              busy  <= 1'b0;
            end else begin
              count <= count - 1'b1;
            end
          end

          default: begin
            state <= IDLE;
            count <= '0;
            pulse <= 1'b0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ps.o_pulse    = pulse;
  assign ps.o_busy     = busy;
  assign ps.o_done     = done;
  assign ps.o_drop_cnt = drop_cnt;

endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
Converts single-cycle trigger pulses into an output pulse of programmable width, followed by a programmable low guard gap. It is the inverse of the channel unit's edge-to-oneshot conversion: the oneshot reduces a level to one cycle, and this block expands one cycle back to a timed level. It sits in the channel unit after the oneshot and drives gating and strobe lines that need a minimum high time. It also counts triggers it drops so that software can detect them.

Parameters:
CNT_W, 16, width of the pulse-width and gap counters and of the i_width/i_gap inputs
DROP_W, 8, width of the saturating dropped-trigger counter

Ports:
i_clk  input  1  system clock; all logic on posedge
i_reset  input  1  asynchronous active-low reset
i_enable  input  1  block enable; low aborts activity and ignores triggers
i_trig  input  1  trigger; each high cycle is one trigger event
i_width  input  CNT_W  high time in cycles, latched at trigger acceptance; 0 is treated as 1
i_gap  input  CNT_W  forced low time after a pulse, latched at acceptance; 0 means no gap
i_retrig  input  1  1 = a trigger during HIGH reloads the width; 0 = it is dropped
i_clr_drop  input  1  synchronous clear of o_drop_cnt
o_pulse  output  1  stretched pulse, registered
o_busy  output  1  high whenever state != IDLE, registered
o_done  output  1  one-cycle strobe in the first low cycle after a normally completed pulse
o_drop_cnt  output  DROP_W  saturating count of dropped triggers

Behaviour:
- Reset (i_reset=0, asynchronous): state=IDLE, counters=0, o_pulse=0, o_busy=0, o_done=0, o_drop_cnt=0.
- States: IDLE, HIGH, GAP. o_pulse=1 exactly while state==HIGH. All outputs are registered.
- IDLE: if i_enable=1 and i_trig=1, accept the trigger:
  - latch W=max(i_width,1) and G=i_gap;
  - go to HIGH with count=W.
  - o_pulse rises on the clock edge after the trigger is sampled, so latency is 1 cycle.
  - If i_enable=0, i_trig is ignored and not counted.
- HIGH: count decrements each cycle. After exactly W cycles in HIGH:
  - go to GAP if G>0, otherwise go to IDLE;
  - o_done=1 for the one cycle where o_pulse first reads 0.
- Trigger while in HIGH:
  - with i_retrig=1, reload count=max(i_width,1) and re-latch G. The pulse stays high for the cycles already elapsed plus the new W counted from the next cycle. There is no glitch low.
  - with i_retrig=0, the trigger is dropped and o_drop_cnt increments.
- GAP: o_pulse=0 for exactly G cycles, then go to IDLE.
  - Any trigger while in GAP is dropped and counted, regardless of i_retrig.
  - Minimum low time between accepted pulses is G+1 cycles (the GAP cycles plus the IDLE sampling cycle). With G=0 it is 1 cycle.
- i_enable=0 while in HIGH or GAP: next cycle state=IDLE and o_pulse=0, with no o_done. Counters are cleared. Triggers in that cycle are not counted.
- o_drop_cnt saturates at 2^DROP_W-1 and does not wrap. If i_clr_drop and a drop occur in the same cycle, the clear wins and the result is 0.
- Changes to i_width/i_gap outside acceptance or retrigger cycles have no effect on the pulse in progress.
- Asynchronous reset asserted mid-pulse forces o_pulse low immediately, without waiting for a clock edge.

Test Plan:
- Width=5, gap=0, single trigger at cycle 10 -> o_pulse high cycles 11-15, o_done at cycle 16, o_busy high cycles 11-15, drop=0.
- Width=0, single trigger -> o_pulse high for exactly 1 cycle, then o_done.
- Width=4, gap=3, i_retrig=0, triggers at cycles 10, 12, 16 -> one pulse in cycles 11-14 with GAP in 15-17; triggers at 12 and 16 dropped; o_drop_cnt=2; a trigger at 18 is accepted and its pulse starts at 19.
- Width=4, i_retrig=1, triggers at 10 and 12 -> o_pulse high continuously in cycles 11-16 (6 cycles), single o_done at 17, drop=0.
- DROP_W=8, 300 triggers forced into GAP -> o_drop_cnt holds 255; i_clr_drop pulsed together with a drop -> 0.
- i_enable dropped at cycle 13 of a 10-wide pulse -> o_pulse low at 14 with no o_done. Async i_reset asserted mid-HIGH -> o_pulse low before the next edge and all outputs at reset values.
